// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel timer: channel mode encodings and
// default widths used by the interface, channel and top.
package timer_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 32;
    localparam int PSC_W_DEF  = 16;

endpackage

// File: rtl/timer_mc_if.sv
// Configuration/control and status bundle between the register slave (master)
// and the timer block (slave). Per-channel fields are flattened, channel i at [i*W +: W].
interface timer_mc_if
    import timer_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PSC_W  = PSC_W_DEF
);
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       ch_rst;
    logic [NUM_CH-1:0]       ch_mode;
    logic [NUM_CH*PSC_W-1:0] ch_psc;
    logic [NUM_CH*CNT_W-1:0] ch_reload;
    logic [NUM_CH*CNT_W-1:0] ch_cmp;
    logic [NUM_CH-1:0]       irq_clr;
    logic [NUM_CH-1:0]       ch_irq;
    logic [NUM_CH-1:0]       ch_running;
    logic [NUM_CH*CNT_W-1:0] ch_cnt;
    logic [NUM_CH-1:0]       pwm_out;

    modport master (
        output ch_en, ch_rst, ch_mode, ch_psc, ch_reload, ch_cmp, irq_clr,
        input  ch_irq, ch_running, ch_cnt, pwm_out
    );

    modport slave (
        input  ch_en, ch_rst, ch_mode, ch_psc, ch_reload, ch_cmp, irq_clr,
        output ch_irq, ch_running, ch_cnt, pwm_out
    );
endinterface

// File: rtl/timer_ch.sv
// One timer channel: prescaler, reloadable up-counter, sticky irq and compare PWM.
// Config is sampled into shadows only at enable, channel clear and periodic wrap.
module timer_ch
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic [PSC_W-1:0] psc,
    input  logic [CNT_W-1:0] reload,
    input  logic [CNT_W-1:0] cmp,
    input  logic             irq_clr,
    output logic             irq,
    output logic             running,
    output logic [CNT_W-1:0] cnt,
    output logic             pwm
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PSC_W-1:0] PSC_ONE = {{(PSC_W-1){1'b0}}, 1'b1};

    logic             en_d_r, running_r, irq_r, pwm_r;
    logic [CNT_W-1:0] cnt_r, reload_sh_r, cmp_sh_r;
    logic [PSC_W-1:0] psc_cnt_r, psc_sh_r;

    logic             tick_s, term_s, rise_s, load_sh_s;
    logic             running_nx_s, irq_nx_s, pwm_nx_s;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [PSC_W-1:0] psc_nx_s;

    // Next-state: clear beats disable beats enable-edge beats tick; a terminal irq beats irq_clr.
    always_comb begin
        tick_s       = running_r & (psc_cnt_r == psc_sh_r);
        term_s       = tick_s & (cnt_r == reload_sh_r);
        rise_s       = en & ~en_d_r;
        running_nx_s = running_r;
        cnt_nx_s     = cnt_r;
        psc_nx_s     = psc_cnt_r;
        load_sh_s    = 1'b0;
        irq_nx_s     = irq_r & ~irq_clr;
        if (clr) begin
            cnt_nx_s     = {CNT_W{1'b0}};
            psc_nx_s     = {PSC_W{1'b0}};
            running_nx_s = en;
            load_sh_s    = 1'b1;
            irq_nx_s     = 1'b0;
        end else if (!en) begin
            cnt_nx_s     = {CNT_W{1'b0}};
            psc_nx_s     = {PSC_W{1'b0}};
            running_nx_s = 1'b0;
        end else if (rise_s) begin
            cnt_nx_s     = {CNT_W{1'b0}};
            psc_nx_s     = {PSC_W{1'b0}};
            running_nx_s = 1'b1;
            load_sh_s    = 1'b1;
        end else if (tick_s) begin
            psc_nx_s = {PSC_W{1'b0}};
            if (term_s) begin
                irq_nx_s = 1'b1;
                if (mode == MODE_ONESHOT) begin
                    running_nx_s = 1'b0;
                end else begin
                    cnt_nx_s  = {CNT_W{1'b0}};
                    load_sh_s = 1'b1;
                end
            end else begin
                cnt_nx_s = cnt_r + CNT_ONE;
            end
        end else if (running_r) begin
            psc_nx_s = psc_cnt_r + PSC_ONE;
        end else begin
            psc_nx_s = psc_cnt_r;
        end
        // PWM lags the counter by one cycle and is forced low whenever the channel stops.
        pwm_nx_s = running_nx_s & running_r & ~clr & (cnt_r < cmp_sh_r);
    end

    // Channel state and shadow registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            en_d_r      <= 1'b0;
            running_r   <= 1'b0;
            irq_r       <= 1'b0;
            pwm_r       <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            psc_cnt_r   <= {PSC_W{1'b0}};
            psc_sh_r    <= {PSC_W{1'b0}};
            reload_sh_r <= {CNT_W{1'b0}};
            cmp_sh_r    <= {CNT_W{1'b0}};
        end else begin
            en_d_r    <= en;
            running_r <= running_nx_s;
            irq_r     <= irq_nx_s;
            pwm_r     <= pwm_nx_s;
            cnt_r     <= cnt_nx_s;
            psc_cnt_r <= psc_nx_s;
            if (load_sh_s) begin
                psc_sh_r    <= psc;
                reload_sh_r <= reload;
                cmp_sh_r    <= cmp;
            end
        end
    end

    assign irq     = irq_r;
    assign running = running_r;
    assign cnt     = cnt_r;
    assign pwm     = pwm_r;

endmodule

// File: rtl/timer_mc.sv
// Multi-channel timer top: NUM_CH independent timer_ch instances, each wired
// to its own slice of the flattened configuration and status buses.
module timer_mc
    import timer_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PSC_W  = PSC_W_DEF
) (
    input logic       hclk,
    input logic       hresetn,
    timer_mc_if.slave bus
);
    logic [NUM_CH-1:0]       irq_s, running_s, pwm_s;
    logic [NUM_CH*CNT_W-1:0] cnt_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_ch #(
            .CNT_W (CNT_W),
            .PSC_W (PSC_W)
        ) u_ch (
            .hclk    (hclk),
            .hresetn (hresetn),
            .en      (bus.ch_en[i]),
            .clr     (bus.ch_rst[i]),
            .mode    (bus.ch_mode[i]),
            .psc     (bus.ch_psc[i*PSC_W +: PSC_W]),
            .reload  (bus.ch_reload[i*CNT_W +: CNT_W]),
            .cmp     (bus.ch_cmp[i*CNT_W +: CNT_W]),
            .irq_clr (bus.irq_clr[i]),
            .irq     (irq_s[i]),
            .running (running_s[i]),
            .cnt     (cnt_s[i*CNT_W +: CNT_W]),
            .pwm     (pwm_s[i])
        );
    end

    assign bus.ch_irq     = irq_s;
    assign bus.ch_running = running_s;
    assign bus.ch_cnt     = cnt_s;
    assign bus.pwm_out    = pwm_s;

endmodule
